// File: rtl/lfsr_checker.sv
// Serial LFSR sequence checker: self-synchronises to the incoming stream, locks after a run of matches,
// and flags bit errors while locked. Optional error counter built when LFSR_CHECKER_ERRCNT_EN is defined.
module lfsr_checker #(
   parameter int             N        = 3,
   parameter logic [N-1:0]   TAPS     = 3'b011,
   parameter int             LOCK_CNT = 8,
   parameter int             LOSS_CNT = 4,
   parameter int             ERR_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   input  logic             clr_err,
   output logic             locked,
   output logic             bit_err,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int LDW = $clog2(N + 1);
   localparam int MCW = $clog2(LOCK_CNT + 1);
   localparam int LSW = $clog2(LOSS_CNT + 1);

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

   state_t         state_q;
   logic [N-1:0]   r_q;       // r_q[N-1] is stage 1 (newest bit), r_q[0] is stage N
   logic [LDW-1:0] ld_q;
   logic [MCW-1:0] mc_q;
   logic [LSW-1:0] ls_q;
   logic           locked_q;
   logic           bit_err_q;

   logic pred, mism, r_zero;

   always_comb begin
      pred   = ^(r_q & TAPS);
      mism   = (din != pred);
      r_zero = (r_q == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= SEARCH;
         r_q       <= '0;
         ld_q      <= '0;
         mc_q      <= '0;
         ls_q      <= '0;
         locked_q  <= 1'b0;
         bit_err_q <= 1'b0;
      end else begin
         bit_err_q <= 1'b0;
         if (din_valid) begin
            case (state_q)
               SEARCH: begin
                  r_q <= {din, r_q[N-1:1]};
                  if (ld_q == LDW'(N - 1)) begin
                     ld_q    <= '0;
                     mc_q    <= '0;
                     state_q <= VERIFY;
                  end else begin
                     ld_q <= ld_q + 1'b1;
                  end
               end
               VERIFY: begin
                  r_q <= {din, r_q[N-1:1]};
                  // an all-zero register predicts zero forever; never let it build a match run
                  if (r_zero || mism) begin
                     mc_q <= '0;
                  end else if (mc_q == MCW'(LOCK_CNT - 1)) begin
                     mc_q     <= '0;
                     ls_q     <= '0;
                     state_q  <= LOCKED;
                     locked_q <= 1'b1;
                  end else begin
                     mc_q <= mc_q + 1'b1;
                  end
               end
               LOCKED: begin
                  // free-run on the prediction so a corrupted din does not pollute R
                  r_q <= {pred, r_q[N-1:1]};
                  if (mism) begin
                     bit_err_q <= 1'b1;
                     if (ls_q == LSW'(LOSS_CNT - 1)) begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                        r_q      <= '0;
                        ld_q     <= '0;
                        mc_q     <= '0;
                        ls_q     <= '0;
                     end else begin
                        ls_q <= ls_q + 1'b1;
                     end
                  end else begin
                     ls_q <= '0;
                  end
               end
               default: begin
                  state_q  <= SEARCH;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign locked  = locked_q;
   assign bit_err = bit_err_q;

`ifdef LFSR_CHECKER_ERRCNT_EN
   logic [ERR_W-1:0] err_q, err_d;
   logic             cnt_hit;

   always_comb begin
      cnt_hit = din_valid && (state_q == LOCKED) && mism;
      err_d   = err_q;
      if (clr_err)
         err_d = cnt_hit ? ERR_W'(1) : '0;
      else if (cnt_hit && (err_q != '1))
         err_d = err_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) err_q <= '0;
      else       err_q <= err_d;
   end

   assign err_cnt = err_q;
`else
   logic unused_clr_err;
   assign unused_clr_err = clr_err;
   assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a default instance and an ERR_W=4 instance share one stimulus stream.
module tb_lfsr_checker;
   logic        clk = 1'b0;
   logic        reset, din, din_valid, clr_err;
   logic        lk_a, be_a, lk_b, be_b;
   logic [15:0] ec_a;
   logic [3:0]  ec_b;

   always #5 clk = ~clk;

   lfsr_checker dut_a (.clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clr_err(clr_err),
                       .locked(lk_a), .bit_err(be_a), .err_cnt(ec_a));
   lfsr_checker #(.ERR_W(4)) dut_b (.clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
                       .clr_err(clr_err), .locked(lk_b), .bit_err(be_b), .err_cnt(ec_b));

`ifdef LFSR_CHECKER_ERRCNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   typedef struct packed { logic lk; logic be; logic [15:0] e16; logic [3:0] e4; } exp_t;
   exp_t sb[$];

   int n_assert = 0, n_fail = 0;
   logic [1:3] mr;
   int ms, mload, mmatch, mloss, merr16, merr4;
   logic mbe;
   logic [0:6] pat = 7'b1011100;
   int sidx = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic b, input logic v, input logic c, input logic r);
      logic pred, hit;
      exp_t e;
      hit = 1'b0;
      mbe = 1'b0;
      if (r) begin
         mr = '0; ms = 0; mload = 0; mmatch = 0; mloss = 0; merr16 = 0; merr4 = 0;
      end else begin
         if (v) begin
            pred = ^(mr & 3'b011);
            case (ms)
               0: begin
                  mr = {b, mr[1:2]};
                  mload++;
                  if (mload == 3) begin ms = 1; mload = 0; mmatch = 0; end
               end
               1: begin
                  if (mr == 3'b000 || b != pred) mmatch = 0;
                  else mmatch++;
                  mr = {b, mr[1:2]};
                  if (mmatch == 8) begin ms = 2; mmatch = 0; mloss = 0; end
               end
               default: begin
                  mr = {pred, mr[1:2]};
                  if (b != pred) begin
                     mbe = 1'b1; hit = 1'b1; mloss++;
                     if (mloss == 4) begin ms = 0; mr = '0; mload = 0; mmatch = 0; mloss = 0; end
                  end else mloss = 0;
               end
            endcase
         end
         if (c) begin
            merr16 = hit ? 1 : 0; merr4 = hit ? 1 : 0;
         end else if (hit) begin
            if (merr16 < 65535) merr16++;
            if (merr4 < 15) merr4++;
         end
      end
      e.lk  = (ms == 2);
      e.be  = mbe;
      e.e16 = CNT_ON ? 16'(merr16) : 16'd0;
      e.e4  = CNT_ON ? 4'(merr4) : 4'd0;
      sb.push_back(e);
   endtask

   task automatic step(input logic b, input logic v, input logic c, input logic r);
      exp_t e;
      @(negedge clk);
      din = b; din_valid = v; clr_err = c; reset = r;
      model(b, v, c, r);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("locked_a", 16'(lk_a), 16'(e.lk));
      chk("locked_b", 16'(lk_b), 16'(e.lk));
      chk("bit_err_a", 16'(be_a), 16'(e.be));
      chk("bit_err_b", 16'(be_b), 16'(e.be));
      chk("err_cnt_a", ec_a, e.e16);
      chk("err_cnt_b", 16'(ec_b), 16'(e.e4));
   endtask

   task automatic good(input int n);
      for (int i = 0; i < n; i++) begin
         step(pat[sidx % 7], 1'b1, 1'b0, 1'b0);
         sidx++;
      end
   endtask

   task automatic bad(input logic c);
      step(~pat[sidx % 7], 1'b1, c, 1'b0);
      sidx++;
   endtask

   initial begin
      int vcnt;
      din = 0; din_valid = 0; clr_err = 0; reset = 1;
      // reset state
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("reset_locked", 16'(lk_a), 16'd0);
      chk("reset_err", ec_a, 16'd0);

      // clean lock: exactly after the 11th valid bit
      sidx = 0;
      for (int i = 1; i <= 11; i++) begin
         good(1);
         if (i == 10) chk("lock_not_at_10", 16'(lk_a), 16'd0);
         if (i == 11) chk("lock_at_11", 16'(lk_a), 16'd1);
      end
      good(10);
      chk("clean_err", ec_a, 16'd0);

      // single error while locked
      bad(1'b0);
      chk("single_berr", 16'(be_a), 16'd1);
      chk("single_locked", 16'(lk_a), 16'd1);
      good(1);
      chk("single_berr_gone", 16'(be_a), 16'd0);
      good(9);
      chk("single_err_cnt", ec_a, CNT_ON ? 16'd1 : 16'd0);
      chk("single_still_locked", 16'(lk_a), 16'd1);

      // loss of lock and re-lock
      for (int i = 1; i <= 4; i++) begin
         bad(1'b0);
         if (i == 3) chk("loss_not_yet", 16'(lk_a), 16'd1);
      end
      chk("loss_after_4", 16'(lk_a), 16'd0);
      good(10);
      chk("relock_not_at_10", 16'(lk_a), 16'd0);
      good(1);
      chk("relock_at_11", 16'(lk_a), 16'd1);

      // valid gaps: same lock point counted in valid bits
      step(1'b0, 1'b0, 1'b0, 1'b1);
      vcnt = 0;
      while (vcnt < 11) begin
         if ($urandom_range(0, 2) == 0) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
         else begin
            good(1);
            vcnt++;
            if (vcnt == 10) chk("gap_not_at_10", 16'(lk_a), 16'd0);
         end
      end
      chk("gap_lock_at_11", 16'(lk_a), 16'd1);

      // reset mid-verify wins over valid and clr_err
      step(1'b0, 1'b0, 1'b0, 1'b1);
      good(5);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("midreset_locked", 16'(lk_a), 16'd0);
      chk("midreset_berr", 16'(be_a), 16'd0);
      chk("midreset_err", ec_a, 16'd0);

      // all-zero stream never locks
      for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("zero_never_locks", 16'(lk_a), 16'd0);

      // saturation on the 4-bit counter, then clear with simultaneous error
      step(1'b0, 1'b0, 1'b0, 1'b1);
      good(11);
      for (int i = 0; i < 20; i++) begin
         bad(1'b0);
         good(2);
      end
      chk("sat_err4", 16'(ec_b), CNT_ON ? 16'd15 : 16'd0);
      chk("sat_err16", ec_a, CNT_ON ? 16'd20 : 16'd0);
      chk("sat_locked", 16'(lk_b), 16'd1);
      bad(1'b1);
      chk("clr_with_err_b", 16'(ec_b), CNT_ON ? 16'd1 : 16'd0);
      chk("clr_with_err_a", ec_a, CNT_ON ? 16'd1 : 16'd0);
      step(pat[sidx % 7], 1'b1, 1'b1, 1'b0);
      sidx++;
      chk("clr_alone", 16'(ec_b), 16'd0);

      if (sb.size() != 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
